// File: rtl/zero_flag_detector.sv
// zero_flag_detector: two-stage valid/ready zero/ones/masked/equality flag unit.
// Optional sticky match flag enabled by defining ZERO_FLAG_STICKY_EN.
module zero_flag_detector #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Z,
    output logic             N,
`ifdef ZERO_FLAG_STICKY_EN
    input  logic             clr_sticky,
    output logic             sticky_z,
`endif
    output logic [CNT_W-1:0] run_cnt
);

    localparam int NCH = WIDTH / CHUNK;

    logic [WIDTH-1:0] w_v;
    logic [NCH-1:0]   w_chunk_z;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_s2_load;
    logic             w_s1_open;

    logic             r_s1_valid;
    logic [NCH-1:0]   r_s1_chunk_z;
    logic             r_s1_n;
    logic             r_s2_valid;
    logic             r_s2_z;
    logic             r_s2_n;
    logic [CNT_W-1:0] r_run_cnt;

    // Select the vector whose all-zero state means "match" for this mode
    always_comb begin
        w_v = a;
        unique case (mode)
            2'd0: w_v = a;
            2'd1: w_v = ~a;
            2'd2: w_v = a & mask;
            2'd3: w_v = a ^ b;
            default: w_v = a;
        endcase
    end

    // Per-chunk zero reduction feeding stage 1
    for (genvar k = 0; k < NCH; k++) begin : g_chunk
        assign w_chunk_z[k] = ~|w_v[k*CHUNK +: CHUNK];
    end

    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign w_s1_open = ~r_s1_valid | w_s2_load;
    assign in_ready  = ~r_s1_valid | ~r_s2_valid | out_ready;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = r_s2_valid & out_ready;

    // Stage 1: capture chunk flags and sign on input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_chunk_z <= '0;
            r_s1_n       <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_open) begin
            r_s1_valid <= w_in_hs;
            if (w_in_hs) begin
                r_s1_chunk_z <= w_chunk_z;
                r_s1_n       <= a[WIDTH-1];
            end
        end
    end

    // Stage 2: combine chunk flags into Z, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_z     <= 1'b0;
            r_s2_n     <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_z     <= &r_s1_chunk_z;
            r_s2_n     <= r_s1_n;
        end else if (w_out_hs) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Saturating count of consecutive delivered matches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (w_out_hs) begin
            if (!r_s2_z)
                r_run_cnt <= '0;
            else if (r_run_cnt != {CNT_W{1'b1}})
                r_run_cnt <= r_run_cnt + CNT_W'(1);
        end
    end

`ifdef ZERO_FLAG_STICKY_EN
    logic r_sticky;

    // Sticky match: set on delivered match, set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= 1'b0;
        else if (w_out_hs && r_s2_z)
            r_sticky <= 1'b1;
        else if (clr_sticky)
            r_sticky <= 1'b0;
    end

    assign sticky_z = r_sticky;
`endif

    assign out_valid = r_s2_valid;
    assign Z         = r_s2_z;
    assign N         = r_s2_n;
    assign run_cnt   = r_run_cnt;

endmodule
